hwag_out_sched: RTL
===================

Name: hwag_out_sched

Overview:
- Downstream consumer of the angle generator core.
- Takes the synchronised crank angle counter (0..3839, 64 sub-angles per tooth, 60 teeth) and the generator-running flag.
- Drives CH_NUM angle-windowed output channels (ignition/injection strobes) from programmable set/reset angles.
- Replaces hard-wired per-channel comparators with double-buffered registers. Updates commit only at the angle wrap, so a window never tears mid-revolution.

Parameters:
- CH_NUM, 4, number of output channels.
- ACNT_WIDTH, 24, width of the angle counter bus.
- ACNT_TOP, 3839, last angle value before wrap to 0.

Ports:
- clk  in  1  module clock.
- rst  in  1  reset, synchronous, active-low.
- hwag_start  in  1  angle generator synchronised/running.
- acnt  in  ACNT_WIDTH  current angle from the angle counter.
- ch_ena  in  CH_NUM  per-channel output enable, applied combinationally into the output register.
- wr_en  in  1  register write strobe.
- wr_addr  in  $clog2(CH_NUM)+1  {channel, sel}; sel 0 = set angle, 1 = reset angle.
- wr_data  in  ACNT_WIDTH  angle value to write.
- wr_err  out  1  one-cycle pulse: the write was rejected.
- upd_pend  out  1  shadow holds data not yet committed.
- ch_out  out  CH_NUM  channel outputs.

Behaviour:
- Reset (rst=0 at a clk edge): all shadow and active set/reset registers, ch_out, wr_err, upd_pend and acnt_d cleared to 0.
- acnt_d: acnt registered each cycle.
- wrap event: acnt==0 and acnt_d==ACNT_TOP, with hwag_start=1.
- Write:
  - wr_en with wr_data <= ACNT_TOP stores to shadow[ch][sel] and sets upd_pend next cycle.
  - wr_data > ACNT_TOP, or channel index >= CH_NUM: shadow unchanged; wr_err=1 for the following cycle only.
- Commit:
  - Shadow copies to active on a wrap event, or in any cycle with hwag_start=0 (immediate update while stopped).
  - upd_pend clears on commit.
- Simultaneous write and commit: commit uses the pre-write shadow. The new write stays in shadow and upd_pend remains 1.
- Window decode per channel (active values s, r):
  - s < r: active when s <= acnt < r.
  - s > r (window spans wrap): active when acnt >= s or acnt < r.
  - s == r: never active (channel disabled).
  - Range compare, not equality. Synchronisation reloads or skipped angles therefore cannot leave an output stuck.
- ch_out[i] <= hwag_start & ch_ena[i] & active_i, registered. Latency is one clk from the acnt change to ch_out.
- A commit at wrap takes effect on ch_out in the cycle after the commit, i.e. two clks after acnt reads 0.
- hwag_start falling: all ch_out low on the next clk edge, regardless of window.
- Reset mid-operation: outputs low on the next edge. Pending writes are lost.
- acnt values > ACNT_TOP are never produced upstream. If seen, they are treated as plain numbers; no error is flagged.

Decomposition:
- Shared package hwag_pkg:
  - ACNT_WIDTH, ACNT_TOP (3839), ANGLE_PER_TOOTH (64), TEETH_TOTAL (60).
  - Typedef angle_t (logic [ACNT_WIDTH-1:0]).
  - Typedef ch_regs_t struct {angle_t set; angle_t rst_a;}.
- One sub-module hwag_out_window:
  - Per channel: active set/reset registers, the wrapped range compare and the output flop.
  - Instantiated CH_NUM times by generate.
  - Shadow registers, write decode, wrap detection and upd_pend/wr_err stay in the top level.

Test Plan:
- Basic window:
  - Stimulus: hwag_start=0; write ch0 set=1152, reset=1216; ch_ena=4'b0001; raise hwag_start; sweep acnt 0..3839 one step per 4 clks.
  - Required: ch_out[0] rises one clk after acnt=1152 and falls one clk after acnt=1216; other channels stay 0.
- Wrapped window:
  - Stimulus: ch1 set=3800, reset=64.
  - Required: ch_out[1] high for acnt 3800..3839 and 0..63, continuous across the wrap; low at acnt=64 (+1 clk).
- Shadow commit:
  - Stimulus: while running with ch2 = 3072/3136, write ch2 set=4000 at acnt=100.
  - Required: wr_err=1 one cycle later; ch2 timing unchanged.
  - Stimulus: write set=3000 at acnt=100.
  - Required: upd_pend=1; ch2 still opens at 3072 this revolution; commit when acnt goes 3839->0; opens at 3000 the next revolution; upd_pend=0 after the commit.
- Write/commit collision:
  - Stimulus: pending ch3 set=500; second write ch3 set=600 in the same cycle as the wrap event.
  - Required: 500 goes active; upd_pend stays 1; 600 goes active at the following wrap.
- Stop and reset:
  - Stimulus: drop hwag_start mid-window (acnt=1180, ch0 high).
  - Required: ch_out[0]=0 next clk; a write now commits without a wrap, with upd_pend low after 1 clk.
  - Stimulus: assert rst=0 for one clk during a window.
  - Required: all outputs and registers 0 on that edge; no output until reprogrammed.
- Degenerate window:
  - Stimulus: set == reset = 2000, with ch_ena set and sweeping acnt.
  - Required: the channel output never asserts over a full revolution.

Source files
------------

// File: rtl/hwag_pkg.sv
// Shared types and constants for the angle-generator output scheduler.
// One revolution is 60 teeth of 64 sub-angles each, so the angle counter runs 0..3839.
package hwag_pkg;
  localparam int ACNT_WIDTH      = 24;
  localparam int ANGLE_PER_TOOTH = 64;
  localparam int TEETH_TOTAL     = 60;
  localparam int ACNT_TOP        = ANGLE_PER_TOOTH * TEETH_TOTAL - 1;

  typedef logic [ACNT_WIDTH-1:0] angle_t;

  typedef struct packed {
    angle_t set;
    angle_t rst_a;
  } ch_regs_t;

  // Range test rather than equality, so a reload or a skipped angle can never
  // leave a channel stuck high; set == reset disables the channel.
  function automatic logic in_window(angle_t a, angle_t s, angle_t r);
    if (s < r)      return (a >= s) && (a < r);
    else if (s > r) return (a >= s) || (a < r);
    else            return 1'b0;
  endfunction
endpackage

// File: rtl/hwag_out_window.sv
// One output channel: active set/reset angles loaded from the shadow on commit,
// the wrapped window compare and the registered channel output.
module hwag_out_window
  import hwag_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     hwag_start,
  input  angle_t   acnt,
  input  logic     ena,
  input  logic     commit,
  input  ch_regs_t shadow,
  output logic     ch_out
);

  ch_regs_t active;

  always_ff @(posedge clk) begin
    if (!rst) begin
      active <= '0;
      ch_out <= 1'b0;
    end else begin
      if (commit) active <= shadow;
      // Compare uses the pre-commit active values, so a commit shows on ch_out one clk later.
      ch_out <= hwag_start & ena & in_window(acnt, active.set, active.rst_a);
    end
  end

endmodule

// File: rtl/hwag_out_sched.sv
// Angle-windowed output scheduler: double-buffered per-channel set/reset angles
// that commit only at the revolution wrap (or continuously while the generator is stopped).
module hwag_out_sched #(
  parameter int CH_NUM     = 4,
  parameter int ACNT_WIDTH = hwag_pkg::ACNT_WIDTH,
  parameter int ACNT_TOP   = hwag_pkg::ACNT_TOP
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      hwag_start,
  input  logic [ACNT_WIDTH-1:0]     acnt,
  input  logic [CH_NUM-1:0]         ch_ena,
  input  logic                      wr_en,
  input  logic [$clog2(CH_NUM):0]   wr_addr,
  input  logic [ACNT_WIDTH-1:0]     wr_data,
  output logic                      wr_err,
  output logic                      upd_pend,
  output logic [CH_NUM-1:0]         ch_out
);
  import hwag_pkg::*;

  localparam int CH_W = $clog2(CH_NUM);

  logic [ACNT_WIDTH-1:0] acnt_d;
  ch_regs_t              shadow [CH_NUM];
  logic [CH_W-1:0]       wr_ch;
  logic                  wr_sel;
  logic                  wr_ok;
  logic                  wrap;
  logic                  commit;

  assign wr_sel = wr_addr[0];
  assign wr_ch  = wr_addr[CH_W:1];
  assign wr_ok  = wr_en && (wr_data <= ACNT_WIDTH'(ACNT_TOP)) && (int'(wr_ch) < CH_NUM);
  assign wrap   = hwag_start && (acnt == '0) && (acnt_d == ACNT_WIDTH'(ACNT_TOP));
  assign commit = wrap || !hwag_start;

  // A write landing on a commit cycle stays pending: the commit takes the old shadow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acnt_d   <= '0;
      wr_err   <= 1'b0;
      upd_pend <= 1'b0;
      for (int i = 0; i < CH_NUM; i++) shadow[i] <= '0;
    end else begin
      acnt_d <= acnt;
      wr_err <= wr_en && !wr_ok;
      if (wr_ok) begin
        upd_pend <= 1'b1;
        if (wr_sel) shadow[wr_ch].rst_a <= angle_t'(wr_data);
        else        shadow[wr_ch].set   <= angle_t'(wr_data);
      end else if (commit) begin
        upd_pend <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    hwag_out_window u_win (
      .clk        (clk),
      .rst        (rst),
      .hwag_start (hwag_start),
      .acnt       (angle_t'(acnt)),
      .ena        (ch_ena[g]),
      .commit     (commit),
      .shadow     (shadow[g]),
      .ch_out     (ch_out[g])
    );
  end

endmodule
